// File: rtl/max_sub_block_16_if.sv
// Stream-in / exp-out bundle for the softmax max-subtract stage.
interface max_sub_block_16_if #(
  parameter int unsigned DATA_SIZE = 16
);
  logic                   s_axis_valid_i;
  logic                   s_axis_ready_o;
  logic                   s_axis_last_i;
  logic [2*DATA_SIZE-1:0] s_axis_data_i;
  logic [DATA_SIZE-1:0]   exp_data_o;
  logic                   exp_data_valid_o;
  logic                   exp_sub_2_done_o;
  logic [DATA_SIZE-1:0]   max_o;

  modport slave (
    input  s_axis_valid_i, s_axis_last_i, s_axis_data_i,
    output s_axis_ready_o, exp_data_o, exp_data_valid_o, exp_sub_2_done_o, max_o
  );

  modport master (
    output s_axis_valid_i, s_axis_last_i, s_axis_data_i,
    input  s_axis_ready_o, exp_data_o, exp_data_valid_o, exp_sub_2_done_o, max_o
  );
endinterface

// File: rtl/max_sub_block_16.sv
// Buffers one signed 1.7.8 vector, tracks its max, then streams x_i - max
// (saturated) to the exp stage and pulses done one cycle after the last element.
module max_sub_block_16 #(
  parameter int unsigned data_size = 16,
  parameter int unsigned MAX_N     = 10
) (
  input logic               clock_i,
  input logic               reset_n_i,
  max_sub_block_16_if.slave axis
);

  localparam int unsigned CNT_W = $clog2(MAX_N + 1);
  localparam int unsigned DIF_W = data_size + 1;

  typedef enum logic [1:0] {IDLE, LOAD, SUB, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [data_size-1:0] max_q, max_d;
  logic [data_size-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic [data_size-1:0] sample_buf_q [MAX_N];

  logic                 hs_c;
  logic                 wr_en_c;
  logic [data_size-1:0] sample_c;
  logic [data_size-1:0] cur_c;
  logic [DIF_W-1:0]     diff_c;
  logic                 unused_low;

  assign sample_c   = axis.s_axis_data_i[2*data_size-1:data_size];
  assign unused_low = ^axis.s_axis_data_i[data_size-1:0];
  assign hs_c       = axis.s_axis_valid_i & ready_q;
  assign cur_c      = sample_buf_q[idx_q];
  assign diff_c     = {cur_c[data_size-1], cur_c} - {max_q[data_size-1], max_q};

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    max_d   = max_q;
    data_d  = data_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    wr_en_c = 1'b0;
    case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (hs_c) begin
          wr_en_c = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (count_q == '0)
            max_d = sample_c;
          else if ($signed(sample_c) > $signed(max_q))
            max_d = sample_c;
          if (axis.s_axis_last_i || (count_q == CNT_W'(MAX_N - 1)))
            state_d = SUB;
        end
      end
      SUB: begin
        // A 17-bit result below -32768 has bit16 set and bit15 clear
        if (diff_c[DIF_W-1] && !diff_c[DIF_W-2])
          data_d = {1'b1, {(data_size-1){1'b0}}};
        else
          data_d = diff_c[data_size-1:0];
        valid_d = 1'b1;
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == count_q - CNT_W'(1))
          state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        count_d = '0;
        idx_d   = '0;
        state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    // Ready only reasserts after a full cycle back in LOAD
    ready_d = (state_q == LOAD) && (state_d == LOAD);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      count_q <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(MAX_N); i++) sample_buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (wr_en_c) sample_buf_q[count_q] <= sample_c;
    end
  end

  assign axis.s_axis_ready_o   = ready_q;
  assign axis.exp_data_o       = data_q;
  assign axis.exp_data_valid_o = valid_q;
  assign axis.exp_sub_2_done_o = done_q;
  assign axis.max_o            = max_q;

endmodule

// File: tb/tb_max_sub_block_16.sv
// Directed bench for max_sub_block_16: output values, latency, done timing, overflow, reset.
module tb_max_sub_block_16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  max_sub_block_16_if #(.DATA_SIZE(16)) axis_if ();

  max_sub_block_16 dut (
    .clock_i   (clk),
    .reset_n_i (rst_n),
    .axis      (axis_if)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] outq [$];
  int          out_cyc [$];
  int          done_cyc [$];
  logic [15:0] done_max [$];
  int          hs_cyc [$];
  int          hs_last = -1;
  int          acc_cnt = 0;
  int          overlap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Log edge numbers of observed events; inputs change at posedge+1 so negedge is stable
  always @(negedge clk) begin
    if (axis_if.exp_data_valid_o) begin
      outq.push_back(axis_if.exp_data_o);
      out_cyc.push_back(cyc);
    end
    if (axis_if.exp_sub_2_done_o) begin
      done_cyc.push_back(cyc);
      done_max.push_back(axis_if.max_o);
    end
    if ((axis_if.exp_data_valid_o || axis_if.exp_sub_2_done_o) && axis_if.s_axis_ready_o)
      overlap++;
    if (axis_if.s_axis_valid_i && axis_if.s_axis_ready_o) begin
      acc_cnt++;
      hs_cyc.push_back(cyc + 1);
      if (axis_if.s_axis_last_i) hs_last = cyc + 1;
    end
  end

  task automatic clear_log();
    outq.delete(); out_cyc.delete(); done_cyc.delete(); done_max.delete(); hs_cyc.delete();
    hs_last = -1; acc_cnt = 0; overlap = 0;
  endtask

  task automatic send(input logic [15:0] d, input bit l);
    int n = 0;
    axis_if.s_axis_valid_i = 1'b1;
    axis_if.s_axis_data_i  = {d, 16'hA5A5};
    axis_if.s_axis_last_i  = l;
    while (axis_if.s_axis_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (axis_if.s_axis_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL send_ready_timeout got=%b exp=1 sample=%h", axis_if.s_axis_ready_o, d);
    end
    @(posedge clk); #1;
    axis_if.s_axis_valid_i = 1'b0;
    axis_if.s_axis_last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input int want);
    int n = 0;
    while (done_cyc.size() < want && n < 200) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (done_cyc.size() < want) begin
      failures++;
      $display("FAIL done_timeout got=%0d exp=%0d", done_cyc.size(), want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    axis_if.s_axis_valid_i = 1'b0;
    axis_if.s_axis_last_i  = 1'b0;
    axis_if.s_axis_data_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (axis_if.s_axis_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", axis_if.s_axis_ready_o); end
    checks++; if (axis_if.exp_data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", axis_if.exp_data_valid_o); end
    checks++; if (axis_if.exp_sub_2_done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", axis_if.exp_sub_2_done_o); end
    checks++; if (axis_if.max_o !== 16'h0000) begin failures++; $display("FAIL reset_max got=%h exp=0000", axis_if.max_o); end
    checks++; if (axis_if.exp_data_o !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", axis_if.exp_data_o); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (axis_if.s_axis_ready_o !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", axis_if.s_axis_ready_o); end
    @(posedge clk); #1;
    checks++; if (axis_if.s_axis_ready_o !== 1'b1) begin failures++; $display("FAIL load_ready got=%b exp=1", axis_if.s_axis_ready_o); end
  endtask

  task automatic test_basic();
    logic [15:0] e [3] = '{16'hFE80, 16'h0000, 16'hFC80};
    clear_log();
    send(16'h0100, 1'b0); send(16'h0280, 1'b0); send(16'hFF00, 1'b1);
    wait_done(1);
    checks++; if (outq.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== e[i]) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, outq[i], e[i]); end
      checks++; if (out_cyc[i] != hs_last + 1 + i) begin failures++; $display("FAIL basic_lat[%0d] got=%0d exp=%0d", i, out_cyc[i], hs_last + 1 + i); end
    end
    checks++; if (done_cyc.size() > 0 && done_cyc[0] != hs_last + 4) begin failures++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc[0], hs_last + 4); end
    checks++; if (axis_if.s_axis_ready_o !== 1'b0) begin failures++; $display("FAIL basic_ready_at_done got=%b exp=0", axis_if.s_axis_ready_o); end
    checks++; if (axis_if.max_o !== 16'h0280) begin failures++; $display("FAIL basic_max got=%h exp=0280", axis_if.max_o); end
    @(negedge clk);
    checks++; if (axis_if.s_axis_ready_o !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", axis_if.s_axis_ready_o); end
    checks++; if (axis_if.exp_sub_2_done_o !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", axis_if.exp_sub_2_done_o); end
    checks++; if (axis_if.max_o !== 16'h0280) begin failures++; $display("FAIL basic_max_hold got=%h exp=0280", axis_if.max_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    clear_log();
    send(16'h8000, 1'b0); send(16'h7F00, 1'b1);
    wait_done(1);
    checks++; if (outq.size() != 2) begin failures++; $display("FAIL sat_count got=%0d exp=2", outq.size()); end
    checks++; if (outq.size() > 0 && outq[0] !== 16'h8000) begin failures++; $display("FAIL sat_data0 got=%h exp=8000", outq[0]); end
    checks++; if (outq.size() > 1 && outq[1] !== 16'h0000) begin failures++; $display("FAIL sat_data1 got=%h exp=0000", outq[1]); end
    checks++; if (axis_if.max_o !== 16'h7F00) begin failures++; $display("FAIL sat_max got=%h exp=7F00", axis_if.max_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    logic [15:0] e;
    clear_log();
    for (int i = 0; i < 10; i++) send(16'(i * 256), 1'b0);
    send(16'h0A00, 1'b0); send(16'h0B00, 1'b1);
    wait_done(2);
    checks++; if (outq.size() != 12) begin failures++; $display("FAIL ovf_count got=%0d exp=12", outq.size()); end
    for (int i = 0; i < 10 && i < outq.size(); i++) begin
      e = 16'(16'hF700 + i * 256);
      checks++; if (outq[i] !== e) begin failures++; $display("FAIL ovf_data[%0d] got=%h exp=%h", i, outq[i], e); end
    end
    checks++; if (outq.size() > 11 && (outq[10] !== 16'hFF00 || outq[11] !== 16'h0000)) begin failures++; $display("FAIL ovf_tail got=%h,%h exp=ff00,0000", outq[10], outq[11]); end
    checks++; if (hs_cyc.size() > 9 && out_cyc.size() > 0 && out_cyc[0] != hs_cyc[9] + 1) begin failures++; $display("FAIL ovf_exit_lat got=%0d exp=%0d", out_cyc[0], hs_cyc[9] + 1); end
    checks++; if (hs_cyc.size() > 10 && hs_cyc[10] != done_cyc[0] + 2) begin failures++; $display("FAIL ovf_resume got=%0d exp=%0d", hs_cyc[10], done_cyc[0] + 2); end
    checks++; if (done_max.size() > 1 && (done_max[0] !== 16'h0900 || done_max[1] !== 16'h0B00)) begin failures++; $display("FAIL ovf_max got=%h,%h exp=0900,0b00", done_max[0], done_max[1]); end
    checks++; if (acc_cnt != 12 || overlap != 0) begin failures++; $display("FAIL ovf_accept got=%0d/%0d exp=12/0", acc_cnt, overlap); end
    @(posedge clk); #1;
  endtask

  task automatic test_bubbles();
    logic [15:0] e [3] = '{16'hFE80, 16'h0000, 16'hFC80};
    clear_log();
    idle(1); send(16'h0100, 1'b0); idle(2); send(16'h0280, 1'b0); idle(3); send(16'hFF00, 1'b1);
    wait_done(1);
    checks++; if (outq.size() != 3) begin failures++; $display("FAIL bub_count got=%0d exp=3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== e[i] || out_cyc[i] != hs_last + 1 + i) begin failures++; $display("FAIL bub_data[%0d] got=%h@%0d exp=%h@%0d", i, outq[i], out_cyc[i], e[i], hs_last + 1 + i); end
    end
    checks++; if (done_cyc.size() > 0 && done_cyc[0] != hs_last + 4) begin failures++; $display("FAIL bub_done_cyc got=%0d exp=%0d", done_cyc[0], hs_last + 4); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sub();
    int n = 0;
    clear_log();
    send(16'h0100, 1'b0); send(16'h0280, 1'b0); send(16'hFF00, 1'b1);
    while (outq.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (axis_if.exp_data_valid_o !== 1'b0 || axis_if.exp_sub_2_done_o !== 1'b0 || axis_if.s_axis_ready_o !== 1'b0)
      begin failures++; $display("FAIL rst_mid_outputs got=v%b d%b r%b exp=000", axis_if.exp_data_valid_o, axis_if.exp_sub_2_done_o, axis_if.s_axis_ready_o); end
    checks++; if (outq.size() != 2) begin failures++; $display("FAIL rst_mid_count got=%0d exp=2", outq.size()); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (axis_if.s_axis_ready_o !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", axis_if.s_axis_ready_o); end
    checks++; if (done_cyc.size() != 0) begin failures++; $display("FAIL rst_mid_done got=%0d exp=0", done_cyc.size()); end
    clear_log();
    send(16'h1234, 1'b1);
    wait_done(1);
    checks++; if (outq.size() != 1 || (outq.size() == 1 && outq[0] !== 16'h0000)) begin failures++; $display("FAIL rst_single got=%0d items exp=1 of 0000", outq.size()); end
    checks++; if (axis_if.max_o !== 16'h1234) begin failures++; $display("FAIL rst_single_max got=%h exp=1234", axis_if.max_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] e [4] = '{16'h0000, 16'hFE00, 16'hFF00, 16'h0000};
    clear_log();
    send(16'h0300, 1'b0); send(16'h0100, 1'b1); send(16'hFE00, 1'b0); send(16'hFF00, 1'b1);
    wait_done(2);
    checks++; if (outq.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      checks++; if (outq[i] !== e[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, outq[i], e[i]); end
    end
    checks++; if (done_cyc.size() > 1 && done_cyc[1] - done_cyc[0] != 6) begin failures++; $display("FAIL b2b_done_spacing got=%0d exp=6", done_cyc[1] - done_cyc[0]); end
    checks++; if (done_max.size() > 1 && (done_max[0] !== 16'h0300 || done_max[1] !== 16'hFF00)) begin failures++; $display("FAIL b2b_max got=%h,%h exp=0300,ff00", done_max[0], done_max[1]); end
    checks++; if (acc_cnt != 4 || overlap != 0) begin failures++; $display("FAIL b2b_accept got=%0d/%0d exp=4/0", acc_cnt, overlap); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overflow();
    test_bubbles();
    test_reset_mid_sub();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
